// File: rtl/audio_gain.sv
// Streaming audio gain stage: FIFO-to-FIFO, two-stage pipeline, Q10 gain multiply and truncating dequantize.
// Define AUDIO_GAIN_SAT_EN to clamp results to the 16-bit DAC range; otherwise results wrap to DATA_WIDTH bits.
module audio_gain #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int GAIN_RESET = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    input  logic [DATA_WIDTH-1:0] vol_in,
    input  logic                  vol_wr,
    output logic [31:0]           sample_cnt
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] ROUND_BIAS = PW'((1 << BITS) - 1);
`ifdef AUDIO_GAIN_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX = PW'(32767);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-32768);
`endif

    logic signed [DATA_WIDTH-1:0] gain;
    logic                         s1_valid;
    logic                         s2_valid;
    logic signed [PW-1:0]         s1_prod;
    logic [DATA_WIDTH-1:0]        s2_data;

    logic                         advance;
    logic signed [PW-1:0]         product;
    logic signed [PW-1:0]         biased;
    logic signed [PW-1:0]         shifted;
    logic [DATA_WIDTH-1:0]        dq_value;

    // A full downstream FIFO freezes every stage at once, so S2 data stays on out_din.
    assign advance   = !s2_valid || !out_full;
    assign in_rd_en  = !reset && !in_empty && advance;
    assign out_wr_en = s2_valid && !out_full;
    assign out_din   = s2_data;

    assign product = PW'($signed(in_dout)) * PW'(gain);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        biased = s1_prod;
        if (s1_prod[PW-1]) begin
            // Bias negatives so the arithmetic shift rounds toward zero instead of toward -inf.
            biased = s1_prod + ROUND_BIAS;
        end
        shifted = biased >>> BITS;
`ifdef AUDIO_GAIN_SAT_EN
        if (shifted > SAT_MAX) begin
            dq_value = DATA_WIDTH'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            dq_value = DATA_WIDTH'(SAT_MIN);
        end else begin
            dq_value = DATA_WIDTH'(shifted);
        end
`else
        dq_value = DATA_WIDTH'(shifted);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gain       <= DATA_WIDTH'(GAIN_RESET);
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_prod    <= '0;
            s2_data    <= '0;
            sample_cnt <= '0;
        end else begin
            // A pop on the same edge as vol_wr still multiplies by the old gain.
            if (vol_wr) begin
                gain <= vol_in;
            end
            if (advance) begin
                s1_valid <= in_rd_en;
                s2_valid <= s1_valid;
                if (in_rd_en) begin
                    s1_prod <= product;
                end
                if (s1_valid) begin
                    s2_data <= dq_value;
                end
            end
            if (out_wr_en) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_gain.sv
// Directed bench for audio_gain: bench-side FIFOs feed and drain the DUT, results checked against hand values.
module tb_audio_gain;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] out_din;
    logic        out_full;
    logic        out_wr_en;
    logic [31:0] vol_in;
    logic        vol_wr;
    logic [31:0] sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [31:0] up_q[$];
    logic signed [31:0] got_q[$];
    logic signed [31:0] last_out;
    int edge_n = 0;
    int pops_n;
    int first_pop_edge;
    int first_wr_edge;
    int last_wr_edge;
    int rd_while_empty = 0;

    audio_gain dut (
        .clock      (clock),
        .reset      (reset),
        .in_dout    (in_dout),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .out_din    (out_din),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .vol_in     (vol_in),
        .vol_wr     (vol_wr),
        .sample_cnt (sample_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        pops_n         = 0;
        first_pop_edge = -1;
        first_wr_edge  = -1;
        last_wr_edge   = -1;
        got_q.delete();
    endtask

    // One clock: present FIFO state at negedge, sample DUT, commit pop/push at posedge, return at posedge+1.
    task automatic tick();
        logic pop;
        logic wr;
        @(negedge clock);
        in_empty = (up_q.size() == 0);
        in_dout  = in_empty ? 32'd0 : up_q[0];
        #1;
        pop      = in_rd_en;
        wr       = out_wr_en;
        last_out = out_din;
        if (pop && in_empty) rd_while_empty++;
        @(posedge clock);
        edge_n++;
        if (pop && up_q.size() > 0) begin
            void'(up_q.pop_front());
            pops_n++;
            if (first_pop_edge < 0) first_pop_edge = edge_n;
        end
        if (wr) begin
            got_q.push_back(last_out);
            if (first_wr_edge < 0) first_wr_edge = edge_n;
            last_wr_edge = edge_n;
        end
        #1;
    endtask

    task automatic run_until(input int n, input string tag);
        int budget = 50;
        while (got_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        if (got_q.size() < n) check({tag, "_timeout"}, got_q.size(), n);
        repeat (3) tick();
    endtask

    task automatic set_gain(input logic [31:0] g);
        vol_in = g;
        vol_wr = 1'b1;
        tick();
        vol_wr = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_empty = 1'b0;
        in_dout  = 32'd123;
        out_full = 1'b0;
        vol_in   = 32'd0;
        vol_wr   = 1'b0;
        clear_stats();

        // Reset state: strobes held low even though upstream claims data
        repeat (2) @(negedge clock);
        #1;
        check("rst_rd_en", in_rd_en, 0);
        check("rst_wr_en", out_wr_en, 0);
        check("rst_out_din", out_din, 0);
        check("rst_cnt", sample_cnt, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Unity gain stream, latency and throughput
        clear_stats();
        up_q = '{32'sd5000, -32'sd7, 32'sd0};
        run_until(3, "unity");
        check("unity_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("unity_0", got_q[0], 5000);
            check("unity_1", got_q[1], -7);
            check("unity_2", got_q[2], 0);
        end
        check("unity_latency", first_wr_edge - first_pop_edge, 2);
        check("unity_rate", last_wr_edge - first_wr_edge, 2);
        check("unity_cnt", sample_cnt, 3);

        // Half gain, truncation toward zero
        set_gain(32'd512);
        clear_stats();
        up_q = '{-32'sd3, 32'sd3};
        run_until(2, "half");
        check("half_n", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("half_neg", got_q[0], -1);
            check("half_pos", got_q[1], 1);
        end

        // Gain 4.0, saturation or wrap depending on build
        set_gain(32'd4096);
        clear_stats();
        up_q = '{32'sd20000, -32'sd20000};
        run_until(2, "big");
        check("big_n", got_q.size(), 2);
        if (got_q.size() == 2) begin
`ifdef AUDIO_GAIN_SAT_EN
            check("big_pos", got_q[0], 32767);
            check("big_neg", got_q[1], -32768);
`else
            check("big_pos", got_q[0], 80000);
            check("big_neg", got_q[1], -80000);
`endif
        end

        // Backpressure: 5 stalled cycles, only two pops fit the pipeline
        set_gain(32'd1024);
        clear_stats();
        out_full = 1'b1;
        up_q = '{32'sd11, 32'sd22, 32'sd33};
        repeat (5) tick();
        check("stall_pops", pops_n, 2);
        check("stall_writes", got_q.size(), 0);
        check("stall_out_din", last_out, 11);
        out_full = 1'b0;
        run_until(3, "stall");
        check("stall_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("stall_0", got_q[0], 11);
            check("stall_1", got_q[1], 22);
            check("stall_2", got_q[2], 33);
        end

        // Gain change on the same edge as a pop
        clear_stats();
        up_q = '{32'sd100, 32'sd100};
        set_gain(32'd2048);
        check("samedge_pop", pops_n, 1);
        run_until(2, "samedge");
        check("samedge_n", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("samedge_old", got_q[0], 100);
            check("samedge_new", got_q[1], 200);
        end
        check("cnt_total", sample_cnt, 12);

        // Reset with S1 and S2 full: flushed samples must never appear
        clear_stats();
        up_q = '{32'sd7, 32'sd8, 32'sd9};
        repeat (2) tick();
        check("flush_pops", pops_n, 2);
        reset = 1'b1;
        #1;
        check("flush_wr_en", out_wr_en, 0);
        check("flush_out_din", out_din, 0);
        check("flush_cnt", sample_cnt, 0);
        @(negedge clock);
        in_empty = (up_q.size() == 0);
        in_dout  = up_q[0];
        #1;
        check("flush_rd_en", in_rd_en, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_until(1, "flush");
        check("flush_n", got_q.size(), 1);
        if (got_q.size() >= 1) check("flush_gain", got_q[0], 9);
        check("flush_cnt_after", sample_cnt, 1);

        check("rd_while_empty", rd_while_empty, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_gain.md
AUDIO_GAIN -- requirements
Module: audio_gain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the sample width in bits, signed, Q10 fixed point.
REQ-002 SHALL have parameter BITS, default 10, the fractional bits of the gain (QUANT_VAL = 2^BITS).
REQ-003 SHALL have parameter GAIN_RESET, default 1024 (1.0 in Q10), the gain value loaded at reset.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_dout, input, DATA_WIDTH, the signed sample from the upstream FIFO.
REQ-007 SHALL have port in_empty, input, 1, which is high when the upstream FIFO has no data.
REQ-008 SHALL have port in_rd_en, output, 1, which pops the upstream FIFO (sample is valid on in_dout in the same cycle).
REQ-009 SHALL have port out_din, output, DATA_WIDTH, the scaled sample to the downstream FIFO.
REQ-010 SHALL have port out_full, input, 1, which is high when the downstream FIFO cannot accept data.
REQ-011 SHALL have port out_wr_en, output, 1, which pushes out_din downstream.
REQ-012 SHALL have port vol_in, input, DATA_WIDTH, the new gain in Q10, signed.
REQ-013 SHALL have port vol_wr, input, 1, which loads vol_in into the gain register on this edge.
REQ-014 SHALL have port sample_cnt, output, 32, the count of samples written downstream since reset.

Function
REQ-015 SHALL form a two-stage pipeline: S1 registers the full-width product in_dout*gain (2*DATA_WIDTH signed); S2 registers the dequantized result.
REQ-016 SHALL define advance = !s2_valid | !out_full; the whole pipeline moves only when advance is high.
REQ-017 SHALL drive in_rd_en = !in_empty & advance, combinationally, and never assert it while in_empty is high.
REQ-018 SHALL drive out_wr_en = s2_valid & !out_full and out_din = S2 data; out_din SHALL be held stable while stalled.
REQ-019 SHALL have a latency of 2: a sample popped at edge k SHALL be presented with out_wr_en during the cycle after edge k+1, given no stall.
REQ-020 SHALL sustain 1 sample/clock when in_empty=0 and out_full=0; bubbles SHALL propagate as s_valid=0 without any write.
REQ-021 SHALL dequantize as signed division by 2^BITS, truncating toward zero (negative products are biased by 2^BITS-1 before the arithmetic shift), matching DEQUANTIZE_I.
REQ-022 SHALL keep only the low DATA_WIDTH bits of the dequantized value when saturation is compiled out.
REQ-023 SHALL apply vol_wr to samples popped on later edges; a sample popped on the same edge as vol_wr SHALL use the old gain.
REQ-024 SHALL accept vol_wr while stalled; samples already in S1/S2 SHALL be unaffected.
REQ-025 SHALL increment sample_cnt on each out_wr_en and wrap from 2^32-1 to 0.

Reset
REQ-026 SHALL, on reset asserted, immediately clear s1_valid, s2_valid, S1/S2 data, out_din and sample_cnt to 0, and set gain to GAIN_RESET.
REQ-027 SHALL hold in_rd_en=0 and out_wr_en=0 while reset is high.
REQ-028 SHALL discard in-flight samples on reset mid-stream; they SHALL never be written after reset is released.

Configuration
REQ-029 SHALL, when macro AUDIO_GAIN_SAT_EN is defined, clamp the dequantized value to [-32768, 32767] (16-bit DAC range) before the S2 register.
REQ-030 SHALL, when AUDIO_GAIN_SAT_EN is undefined, perform no clamping and use the wrap behaviour of REQ-022.

Verification
REQ-031 SHALL cover: gain reset (1024), stream 5000, -7, 0 -> out_din 5000, -7, 0 at 1/clock, latency 2, sample_cnt=3.
REQ-032 SHALL cover: vol_wr 512, input -3 -> -1 (truncation toward zero); input 3 -> 1.
REQ-033 SHALL cover: vol_wr 4096, input 20000 -> 32767 with AUDIO_GAIN_SAT_EN and 80000 without it; input -20000 -> -32768 and -80000 respectively.
REQ-034 SHALL cover: out_full held for 5 cycles with 3 samples queued -> no in_rd_en beyond pipeline capacity, out_din stable, no loss, and correct order on release.
REQ-035 SHALL cover: vol_wr 2048 on the same edge as popping sample 100 -> output 100; the next sample 100 -> output 200.
REQ-036 SHALL cover: reset asserted with S1/S2 valid -> outputs zero at once, gain 1024, and no out_wr_en for the flushed samples.
